// File: rtl/neuro_edge_pkg.sv
// Shared definitions for the neuro-edge crossbar sequencing blocks:
// default geometry, FSM state encoding and a select-width helper.
package neuro_edge_pkg;

  localparam int DEF_TILES         = 4;
  localparam int DEF_TS_WIDTH      = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int SETTLE_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  // Width of a tile index; a single tile still gets one select bit.
  function automatic int sel_width(input int tiles);
    return (tiles > 1) ? $clog2(tiles) : 1;
  endfunction

endpackage

// File: rtl/tiled_crossbar_sequencer_if.sv
// Handshake and status bundle between the crossbar sequencer and its
// controller / accumulator. The master side issues runs and accepts samples.
interface tiled_crossbar_sequencer_if
  import neuro_edge_pkg::*;
#(
  parameter int TILES    = DEF_TILES,
  parameter int TS_WIDTH = DEF_TS_WIDTH
);

  localparam int SEL_W = sel_width(TILES);

  logic                start;
  logic [TS_WIDTH-1:0] num_ts;
  logic                abort;
  logic                sample_rdy;
  logic                busy;
  logic                clear_acc;
  logic                apply_v;
  logic [SEL_W-1:0]    tile_sel;
  logic                sample_i;
  logic [TS_WIDTH-1:0] ts_idx;
  logic                done;
  logic                aborted;

  modport master (
    output start, num_ts, abort, sample_rdy,
    input  busy, clear_acc, apply_v, tile_sel, sample_i, ts_idx, done, aborted
  );

  modport slave (
    input  start, num_ts, abort, sample_rdy,
    output busy, clear_acc, apply_v, tile_sel, sample_i, ts_idx, done, aborted
  );

endinterface

// File: rtl/crossbar_settle_timer.sv
// Dwell timer for the read-voltage settle window: load a count, count it
// down, and flag the last cycle of the window with a one-cycle expire.
module crossbar_settle_timer
  import neuro_edge_pkg::*;
#(
  parameter int WIDTH = SETTLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  // Down-counter: reload on request, otherwise decrement until empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != {WIDTH{1'b0}}) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // A count of one marks the final cycle of the window
  assign o_expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/tiled_crossbar_sequencer.sv
// Sequences read operations over a tiled crossbar: one accumulator clear per
// run, then for every timestep and every row tile a settle window followed by
// a sample handshake. Outputs are registered from the next-state decode so
// they line up with the state the FSM has just entered.
module tiled_crossbar_sequencer
  import neuro_edge_pkg::*;
#(
  parameter int TILES         = DEF_TILES,
  parameter int TS_WIDTH      = DEF_TS_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic                       clk,
  input logic                       rst,
  tiled_crossbar_sequencer_if.slave io_seq
);

  localparam int                  SEL_W       = sel_width(TILES);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  seq_state_e          r_state;
  seq_state_e          w_next_state;
  logic [TS_WIDTH-1:0] r_num_ts;
  logic [TS_WIDTH-1:0] r_ts_idx;
  logic [SEL_W-1:0]    r_tile_sel;
  logic r_busy, r_clear_acc, r_apply_v, r_sample_i, r_done, r_aborted;
  logic w_busy, w_clear_acc, w_apply_v, w_sample_i, w_done, w_aborted;
  logic w_abort_take, w_handshake, w_last_tile, w_last_ts;
  logic w_run_start, w_expire, w_load;

  // Abort only counts while a run is active, and it beats any handshake
  assign w_abort_take = io_seq.abort && (r_state != ST_IDLE);
  assign w_handshake  = (r_state == ST_SAMPLE) && io_seq.sample_rdy && !w_abort_take;
  assign w_last_tile  = (r_tile_sel == SEL_W'(TILES - 1));
  assign w_last_ts    = (r_ts_idx == (r_num_ts - TS_WIDTH'(1)));
  assign w_run_start  = (r_state == ST_IDLE) && io_seq.start &&
                        (io_seq.num_ts != {TS_WIDTH{1'b0}});
  // Arm the settle window on every entry into APPLY
  assign w_load       = (w_next_state == ST_APPLY) && (r_state != ST_APPLY);

  crossbar_settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (SETTLE_LOAD),
    .o_expire   (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; an accepted abort overrides every other transition
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_seq.start) begin
          w_next_state = (io_seq.num_ts == {TS_WIDTH{1'b0}}) ? ST_FINISH : ST_CLEAR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CLEAR: w_next_state = ST_APPLY;
      ST_APPLY: begin
        if (w_expire) begin
          w_next_state = ST_SAMPLE;
        end else begin
          w_next_state = ST_APPLY;
        end
      end
      ST_SAMPLE: begin
        if (!io_seq.sample_rdy) begin
          w_next_state = ST_SAMPLE;
        end else if (!w_last_tile || !w_last_ts) begin
          w_next_state = ST_APPLY;
        end else begin
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
    if (w_abort_take) begin
      w_next_state = ST_IDLE;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // Output decode from the state being entered
  always_comb begin
    w_busy      = 1'b0;
    w_clear_acc = 1'b0;
    w_apply_v   = 1'b0;
    w_sample_i  = 1'b0;
    w_done      = 1'b0;
    w_aborted   = w_abort_take;
    case (w_next_state)
      ST_IDLE:   w_busy = 1'b0;
      ST_CLEAR: begin
        w_busy      = 1'b1;
        w_clear_acc = 1'b1;
      end
      ST_APPLY: begin
        w_busy    = 1'b1;
        w_apply_v = 1'b1;
      end
      ST_SAMPLE: begin
        w_busy     = 1'b1;
        w_apply_v  = 1'b1;
        w_sample_i = 1'b1;
      end
      ST_FINISH: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default:   w_busy = 1'b0;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_clear_acc <= 1'b0;
      r_apply_v   <= 1'b0;
      r_sample_i  <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_busy      <= w_busy;
      r_clear_acc <= w_clear_acc;
      r_apply_v   <= w_apply_v;
      r_sample_i  <= w_sample_i;
      r_done      <= w_done;
      r_aborted   <= w_aborted;
    end
  end

  // Run bookkeeping: capture the run length, walk tiles then timesteps per handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_ts   <= {TS_WIDTH{1'b0}};
      r_ts_idx   <= {TS_WIDTH{1'b0}};
      r_tile_sel <= {SEL_W{1'b0}};
    end else if (w_run_start) begin
      r_num_ts   <= io_seq.num_ts;
      r_ts_idx   <= {TS_WIDTH{1'b0}};
      r_tile_sel <= {SEL_W{1'b0}};
    end else if (w_handshake && !w_last_tile) begin
      r_num_ts   <= r_num_ts;
      r_ts_idx   <= r_ts_idx;
      r_tile_sel <= r_tile_sel + SEL_W'(1);
    end else if (w_handshake && !w_last_ts) begin
      r_num_ts   <= r_num_ts;
      r_ts_idx   <= r_ts_idx + TS_WIDTH'(1);
      r_tile_sel <= {SEL_W{1'b0}};
    end else begin
      r_num_ts   <= r_num_ts;
      r_ts_idx   <= r_ts_idx;
      r_tile_sel <= r_tile_sel;
    end
  end

  assign io_seq.busy      = r_busy;
  assign io_seq.clear_acc = r_clear_acc;
  assign io_seq.apply_v   = r_apply_v;
  assign io_seq.sample_i  = r_sample_i;
  assign io_seq.done      = r_done;
  assign io_seq.aborted   = r_aborted;
  assign io_seq.tile_sel  = r_tile_sel;
  assign io_seq.ts_idx    = r_ts_idx;

endmodule

// File: tb/tb_tiled_crossbar_sequencer.sv
// Self-checking bench for tiled_crossbar_sequencer. Two instances: the
// default geometry (4 tiles, settle 2) and a single-tile, settle-1 build for
// the long run. Offsets are counted in cycles after the edge that accepts
// start; offset 0 is the first cycle of the run. With sample_rdy high, done
// appears at offset 1 + num_ts*TILES*(SETTLE+1); num_ts=0 gives done at 0.
module tb_tiled_crossbar_sequencer;
  import neuro_edge_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct packed {
    logic [7:0] ts;
    logic [1:0] tile;
  } exp0_t;

  exp0_t      q0[$];
  logic [7:0] q1[$];
  exp0_t      e0;
  logic [7:0] e1;

  // Observations gathered by run0 for the scenario tasks to judge
  int obs_clr_cnt, obs_clr_first, obs_hs, obs_done_off, obs_done_cnt;
  int obs_abort_edge, obs_abrt_off, obs_abrt_cnt, obs_q_left;
  bit obs_apply, obs_sample, obs_si_drop, obs_end_busy, obs_end_pulse, obs_timeout;

  tiled_crossbar_sequencer_if #(.TILES(4), .TS_WIDTH(8)) b0 ();
  tiled_crossbar_sequencer_if #(.TILES(1), .TS_WIDTH(8)) b1 ();

  tiled_crossbar_sequencer #(.TILES(4), .TS_WIDTH(8), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .io_seq(b0)
  );

  tiled_crossbar_sequencer #(.TILES(1), .TS_WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .io_seq(b1)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Scoreboard for the 4-tile instance: each handshake must match the next expected ts/tile
  always @(negedge clk) begin
    if (!rst && b0.sample_i && b0.sample_rdy && !b0.abort) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_errors++;
        $display("FAIL sb0_extra: handshake ts=%0d tile=%0d, none expected", b0.ts_idx, b0.tile_sel);
      end else begin
        e0 = q0.pop_front();
        if ({b0.ts_idx, b0.tile_sel} !== e0) begin
          n_errors++;
          $display("FAIL sb0_order: got ts=%0d tile=%0d, expected ts=%0d tile=%0d",
                   b0.ts_idx, b0.tile_sel, e0.ts, e0.tile);
        end
      end
    end
  end

  // Scoreboard for the single-tile instance
  always @(negedge clk) begin
    if (!rst && b1.sample_i && b1.sample_rdy && !b1.abort) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL sb1_extra: handshake ts=%0d, none expected", b1.ts_idx);
      end else begin
        e1 = q1.pop_front();
        if (b1.ts_idx !== e1 || b1.tile_sel !== 1'b0) begin
          n_errors++;
          $display("FAIL sb1_order: got ts=%0d tile=%0d, expected ts=%0d tile=0",
                   b1.ts_idx, b1.tile_sel, e1);
        end
      end
    end
  end

  // Drives one run on the 4-tile instance and records what it does.
  task automatic run0(input int num, input int stall_n, input int abort_ts,
                      input int abort_tile, input int restart_at, input int budget);
    int t;
    int stall_left;
    int end_off;
    bit prev_si;
    bit prev_hs;
    bit abort_sent;
    bit hs;
    obs_clr_cnt = 0; obs_clr_first = -1; obs_hs = 0; obs_done_off = -1; obs_done_cnt = 0;
    obs_abort_edge = -1; obs_abrt_off = -1; obs_abrt_cnt = 0; obs_q_left = 0;
    obs_apply = 1'b0; obs_sample = 1'b0; obs_si_drop = 1'b0;
    obs_end_busy = 1'b1; obs_end_pulse = 1'b1; obs_timeout = 1'b0;
    for (int ts = 0; ts < num; ts++) begin
      for (int tl = 0; tl < 4; tl++) begin
        q0.push_back({8'(ts), 2'(tl)});
      end
    end
    b0.num_ts = 8'(num); b0.start = 1'b1; b0.sample_rdy = 1'b1; b0.abort = 1'b0;
    @(posedge clk); #1;
    b0.start = 1'b0;
    t = 0; stall_left = stall_n; end_off = -1;
    prev_si = 1'b0; prev_hs = 1'b0; abort_sent = 1'b0;
    while (t <= budget) begin
      if (b0.clear_acc) begin
        obs_clr_cnt++;
        if (obs_clr_first < 0) obs_clr_first = t;
      end
      if (b0.apply_v) obs_apply = 1'b1;
      if (b0.sample_i) obs_sample = 1'b1;
      if (prev_si && !prev_hs && !b0.sample_i) obs_si_drop = 1'b1;
      if (b0.done) begin
        obs_done_cnt++;
        if (obs_done_off < 0) obs_done_off = t;
      end
      if (b0.aborted) begin
        obs_abrt_cnt++;
        if (obs_abrt_off < 0) obs_abrt_off = t;
      end
      if (end_off >= 0) begin
        obs_end_busy  = b0.busy;
        obs_end_pulse = b0.done || b0.aborted;
        break;
      end
      if (b0.done || b0.aborted) end_off = t;
      b0.abort = 1'b0;
      b0.start = 1'b0;
      if (t == restart_at) begin
        b0.start  = 1'b1;
        b0.num_ts = 8'd5;
      end
      if (abort_ts >= 0 && !abort_sent && b0.apply_v && !b0.sample_i &&
          int'(b0.ts_idx) == abort_ts && int'(b0.tile_sel) == abort_tile) begin
        b0.abort = 1'b1;
        abort_sent = 1'b1;
        obs_abort_edge = t;
      end
      if (b0.sample_i && stall_left > 0) begin
        b0.sample_rdy = 1'b0;
        stall_left--;
      end else begin
        b0.sample_rdy = 1'b1;
      end
      hs = b0.sample_i && b0.sample_rdy && !b0.abort;
      if (hs) obs_hs++;
      prev_si = b0.sample_i;
      prev_hs = hs;
      @(posedge clk); #1;
      t++;
    end
    if (t > budget) obs_timeout = 1'b1;
    b0.abort = 1'b0; b0.start = 1'b0; b0.sample_rdy = 1'b1;
    obs_q_left = q0.size();
    q0.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.start = 1'b1; b0.num_ts = 8'd3; b0.abort = 1'b1; b0.sample_rdy = 1'b1;
    b1.start = 1'b1; b1.num_ts = 8'd3; b1.abort = 1'b1; b1.sample_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({b0.busy, b0.clear_acc, b0.apply_v, b0.sample_i, b0.done, b0.aborted} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl0: got %b expected 000000",
               {b0.busy, b0.clear_acc, b0.apply_v, b0.sample_i, b0.done, b0.aborted});
    end
    n_checks++;
    if (b0.tile_sel !== 2'd0 || b0.ts_idx !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_idx0: got tile=%0d ts=%0d expected 0 0", b0.tile_sel, b0.ts_idx);
    end
    n_checks++;
    if ({b1.busy, b1.clear_acc, b1.apply_v, b1.sample_i, b1.done, b1.aborted} !== 6'b0 ||
        b1.tile_sel !== 1'b0 || b1.ts_idx !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_dut1: got busy=%b ts=%0d expected all zero", b1.busy, b1.ts_idx);
    end
    rst = 1'b0;
    b0.start = 1'b0; b0.abort = 1'b0;
    b1.start = 1'b0; b1.abort = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.aborted !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got busy=%b done=%b aborted=%b expected 0 0 0",
               b0.busy, b0.done, b0.aborted);
    end
  endtask

  task automatic test_basic();
    run0(3, 0, -1, -1, -1, 200);
    n_checks++;
    if (obs_timeout) begin n_errors++; $display("FAIL basic_timeout: no done within 200 cycles"); end
    n_checks++;
    if (obs_clr_cnt != 1 || obs_clr_first != 0) begin
      n_errors++;
      $display("FAIL basic_clear: got count=%0d at=%0d expected count=1 at=0", obs_clr_cnt, obs_clr_first);
    end
    n_checks++;
    if (obs_hs != 12) begin n_errors++; $display("FAIL basic_handshakes: got %0d expected 12", obs_hs); end
    n_checks++;
    if (obs_done_off != 37 || obs_done_cnt != 1) begin
      n_errors++;
      $display("FAIL basic_done: got offset=%0d pulses=%0d expected offset=37 pulses=1", obs_done_off, obs_done_cnt);
    end
    n_checks++;
    if (obs_end_busy !== 1'b0 || obs_end_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_after_done: got busy=%b pulse=%b expected 0 0", obs_end_busy, obs_end_pulse);
    end
    n_checks++;
    if (obs_q_left != 0) begin n_errors++; $display("FAIL basic_missing: got %0d unserved expected 0", obs_q_left); end
    n_checks++;
    if (b0.ts_idx !== 8'd2 || b0.tile_sel !== 2'd3) begin
      n_errors++;
      $display("FAIL basic_final_idx: got ts=%0d tile=%0d expected ts=2 tile=3", b0.ts_idx, b0.tile_sel);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (b0.ts_idx !== 8'd2 || b0.tile_sel !== 2'd3 || b0.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold: got ts=%0d tile=%0d busy=%b expected ts=2 tile=3 busy=0",
               b0.ts_idx, b0.tile_sel, b0.busy);
    end
  endtask

  task automatic test_stall();
    run0(3, 5, -1, -1, -1, 200);
    n_checks++;
    if (obs_done_off != 42) begin n_errors++; $display("FAIL stall_done: got offset=%0d expected 42", obs_done_off); end
    n_checks++;
    if (obs_si_drop) begin n_errors++; $display("FAIL stall_sample_held: got drop=1 expected 0"); end
    n_checks++;
    if (obs_hs != 12 || obs_q_left != 0) begin
      n_errors++;
      $display("FAIL stall_handshakes: got %0d left=%0d expected 12 left=0", obs_hs, obs_q_left);
    end
  endtask

  task automatic test_zero_ts();
    run0(0, 0, -1, -1, -1, 20);
    n_checks++;
    if (obs_done_off != 0 || obs_done_cnt != 1) begin
      n_errors++;
      $display("FAIL zero_done: got offset=%0d pulses=%0d expected offset=0 pulses=1", obs_done_off, obs_done_cnt);
    end
    n_checks++;
    if (obs_clr_cnt != 0 || obs_apply || obs_sample) begin
      n_errors++;
      $display("FAIL zero_quiet: got clear=%0d apply=%b sample=%b expected 0 0 0", obs_clr_cnt, obs_apply, obs_sample);
    end
    n_checks++;
    if (obs_end_busy !== 1'b0) begin n_errors++; $display("FAIL zero_idle: got busy=%b expected 0", obs_end_busy); end
  endtask

  task automatic test_abort();
    run0(3, 0, 1, 2, -1, 200);
    n_checks++;
    if (obs_abort_edge != 19) begin
      n_errors++;
      $display("FAIL abort_point: got abort at offset=%0d expected 19", obs_abort_edge);
    end
    n_checks++;
    if (obs_abrt_off != 20 || obs_abrt_cnt != 1) begin
      n_errors++;
      $display("FAIL abort_pulse: got offset=%0d pulses=%0d expected offset=20 pulses=1", obs_abrt_off, obs_abrt_cnt);
    end
    n_checks++;
    if (obs_done_cnt != 0 || obs_end_busy !== 1'b0 || obs_hs != 6) begin
      n_errors++;
      $display("FAIL abort_no_done: got done=%0d busy=%b hs=%0d expected 0 0 6", obs_done_cnt, obs_end_busy, obs_hs);
    end
    run0(1, 0, -1, -1, -1, 100);
    n_checks++;
    if (obs_done_off != 13 || obs_hs != 4 || obs_q_left != 0 || obs_clr_cnt != 1) begin
      n_errors++;
      $display("FAIL abort_restart: got done=%0d hs=%0d left=%0d clr=%0d expected 13 4 0 1",
               obs_done_off, obs_hs, obs_q_left, obs_clr_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bit woke;
    run0(1, 0, -1, -1, 3, 100);
    n_checks++;
    if (obs_done_off != 13 || obs_clr_cnt != 1 || obs_hs != 4 || obs_q_left != 0) begin
      n_errors++;
      $display("FAIL busy_start_run: got done=%0d clr=%0d hs=%0d left=%0d expected 13 1 4 0",
               obs_done_off, obs_clr_cnt, obs_hs, obs_q_left);
    end
    woke = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b0.busy || b0.clear_acc) woke = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (woke) begin n_errors++; $display("FAIL busy_start_queued: got busy after run expected idle"); end
  endtask

  task automatic test_reset_mid_sample();
    int  t;
    bit  found;
    bit  bad;
    b0.sample_rdy = 1'b0; b0.num_ts = 8'd2; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    t = 0; found = 1'b0;
    while (t < 20 && !found) begin
      if (b0.sample_i) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    n_checks++;
    if (!found || b0.apply_v !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_sample_reach: got sample_i=%b apply_v=%b expected 1 1", b0.sample_i, b0.apply_v);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({b0.busy, b0.clear_acc, b0.apply_v, b0.sample_i, b0.done, b0.aborted} !== 6'b0 ||
        b0.tile_sel !== 2'd0 || b0.ts_idx !== 8'd0) begin
      n_errors++;
      $display("FAIL rst_mid_run: got ctrl=%b tile=%0d ts=%0d expected all zero",
               {b0.busy, b0.clear_acc, b0.apply_v, b0.sample_i, b0.done, b0.aborted}, b0.tile_sel, b0.ts_idx);
    end
    rst = 1'b0; b0.sample_rdy = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (b0.busy || b0.done || b0.aborted) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_errors++; $display("FAIL rst_quiet: got activity after reset expected idle"); end
  endtask

  task automatic test_long_run();
    int t;
    int done_off;
    int hs;
    int last_ts;
    int clr;
    bit tile_nz;
    for (int ts = 0; ts < 255; ts++) q1.push_back(8'(ts));
    b1.num_ts = 8'd255; b1.sample_rdy = 1'b1; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    t = 0; done_off = -1; hs = 0; last_ts = -1; clr = 0; tile_nz = 1'b0;
    while (t < 700 && done_off < 0) begin
      if (b1.clear_acc) clr++;
      if (b1.tile_sel !== 1'b0) tile_nz = 1'b1;
      if (b1.sample_i && b1.sample_rdy) begin
        hs++;
        last_ts = int'(b1.ts_idx);
      end
      if (b1.done) done_off = t;
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (done_off != 511) begin n_errors++; $display("FAIL long_done: got offset=%0d expected 511", done_off); end
    n_checks++;
    if (hs != 255 || last_ts != 254 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL long_steps: got hs=%0d last_ts=%0d left=%0d expected 255 254 0", hs, last_ts, q1.size());
    end
    n_checks++;
    if (tile_nz || clr != 1) begin
      n_errors++;
      $display("FAIL long_tile: got tile_nonzero=%b clears=%0d expected 0 1", tile_nz, clr);
    end
    q1.delete();
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    b0.start = 1'b0; b0.num_ts = 8'd0; b0.abort = 1'b0; b0.sample_rdy = 1'b1;
    b1.start = 1'b0; b1.num_ts = 8'd0; b1.abort = 1'b0; b1.sample_rdy = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_zero_ts();
    test_abort();
    test_start_while_busy();
    test_reset_mid_sample();
    test_long_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tiled_crossbar_sequencer.md
TILED_CROSSBAR_SEQUENCER -- requirements
Module: tiled_crossbar_sequencer

Interface
REQ-001 Parameter TILES, default 4: number of crossbar row tiles sequenced per timestep, range 1..16.
REQ-002 Parameter TS_WIDTH, default 8: width of the timestep count and index.
REQ-003 Parameter SETTLE_CYCLES, default 2: apply_v cycles before sampling, range 1..255.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  run request; sampled only in IDLE.
REQ-008 num_ts  in  TS_WIDTH  timesteps for the run; captured on the accepted start.
REQ-009 abort  in  1  terminate the active run.
REQ-010 sample_rdy  in  1  downstream accumulator can take a sample.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 clear_acc  out  1  one-cycle accumulator clear at run start.
REQ-013 apply_v  out  1  read voltage applied to the selected tile.
REQ-014 tile_sel  out  max(1,clog2(TILES))  index of the active tile.
REQ-015 sample_i  out  1  current sample request to the accumulator.
REQ-016 ts_idx  out  TS_WIDTH  index of the current timestep.
REQ-017 done  out  1  one-cycle pulse when a run completes normally.
REQ-018 aborted  out  1  one-cycle pulse when a run is aborted.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, APPLY, SAMPLE and FINISH.
REQ-020 IDLE with start=1 and num_ts!=0 -> CLEAR; capture num_ts; set ts_idx=0 and tile_sel=0.
REQ-021 IDLE with start=1 and num_ts==0 -> FINISH directly; no clear_acc, apply_v or sample_i.
REQ-022 CLEAR SHALL last exactly 1 cycle with clear_acc=1, then -> APPLY.
REQ-023 APPLY SHALL last exactly SETTLE_CYCLES cycles with apply_v=1, then -> SAMPLE.
REQ-024 SAMPLE SHALL hold apply_v=1 and sample_i=1 until the cycle in which sample_rdy=1 (handshake cycle).
REQ-025 sample_i SHALL NOT deassert before the handshake.
REQ-026 After a handshake, if tile_sel<TILES-1: increment tile_sel -> APPLY.
REQ-027 After a handshake, else if ts_idx<num_ts-1: tile_sel=0, increment ts_idx -> APPLY.
REQ-028 After a handshake, otherwise -> FINISH.
REQ-029 FINISH SHALL last 1 cycle with done=1, then -> IDLE.
REQ-030 Latency with sample_rdy held at 1: start accepted at edge k gives clear_acc in cycle k+1 and done in cycle k+2+num_ts*TILES*(SETTLE_CYCLES+1).
REQ-031 Each extra cycle with sample_rdy=0 in SAMPLE SHALL add exactly one cycle to the latency.
REQ-032 start while busy SHALL be ignored, without queuing.
REQ-033 abort while busy SHALL force IDLE at the next edge and pulse aborted=1 for that 1 cycle.
REQ-034 An aborted run SHALL produce no done; abort in IDLE SHALL be ignored.
REQ-035 abort SHALL have priority over a simultaneous sample handshake or state transition.
REQ-036 Counters SHALL NOT wrap: ts_idx ends at num_ts-1 and tile_sel ends at TILES-1.
REQ-037 A num_ts of 2^TS_WIDTH-1 SHALL be supported.
REQ-038 In IDLE, tile_sel and ts_idx SHALL hold their last values.

Reset
REQ-039 rst=1 SHALL force IDLE at the next edge, overriding all inputs, including mid-run.
REQ-040 Reset SHALL set busy, clear_acc, apply_v, sample_i, done and aborted to 0, and tile_sel and ts_idx to 0.
REQ-041 Reset SHALL never produce a done or aborted pulse.

Structure
REQ-042 The state enum and the default TILES, TS_WIDTH and SETTLE_CYCLES values SHALL live in the shared package neuro_edge_pkg.
REQ-043 The APPLY dwell counter SHALL be the sub-module crossbar_settle_timer (load, count-down, expire pulse); all other logic stays in the top.
REQ-044 All outputs SHALL be registered.

Verification
REQ-045 TILES=4, SETTLE=2, num_ts=3, sample_rdy=1 -> 1 clear_acc, 12 sample_i handshakes, done 38 cycles after the start edge.
REQ-046 Same setup, sample_rdy=0 for 5 cycles in the first SAMPLE -> sample_i held throughout, done 43 cycles after start.
REQ-047 num_ts=0 -> done in the cycle after start; clear_acc, apply_v and sample_i stay 0.
REQ-048 abort during timestep 1, tile 2 -> aborted pulse, then IDLE, no done; a fresh start then completes normally.
REQ-049 start pulsed while busy, and rst asserted mid-SAMPLE -> start has no effect; after reset, all outputs are 0 and state is IDLE.
REQ-050 TILES=1, SETTLE=1, num_ts=255, sample_rdy=1 -> last ts_idx 254, tile_sel always 0, done at cycle 512.
